program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 10, giving the instruction-memory word-address width (1..16).
REQ-002 The module SHALL have parameter RESET_HOLD, default 4, giving the number of cycles cpu_reset stays high after a verified load (>=1).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port load_start, input, 1 bit: a one-cycle request to begin a load session.
REQ-006 The module SHALL have port data_valid, input, 1 bit: the source presents a word on data_in.
REQ-007 The module SHALL have port data_in, input, 16 bits: the stream word.
REQ-008 The module SHALL have port data_ready, output, 1 bit: the loader accepts a word this cycle.
REQ-009 The module SHALL have port mem_write, output, 1 bit: the instruction-memory write strobe.
REQ-010 The module SHALL have port mem_address, output, ADDR_WIDTH bits: the instruction-memory write address.
REQ-011 The module SHALL have port mem_data, output, 16 bits: the instruction-memory write data.
REQ-012 The module SHALL have port cpu_reset, output, 1 bit: drives the processor fetch/decode/memory reset.
REQ-013 The module SHALL have ports busy, done and error, each output, 1 bit: status signals.

Function
REQ-014 A transfer SHALL occur on a cycle when data_valid and data_ready are both 1; a word held with data_valid=1 and data_ready=0 SHALL NOT be consumed.
REQ-015 The stream format SHALL be: START address word, COUNT word, COUNT instruction words, then a CHECKSUM word.
REQ-016 The FSM SHALL have states IDLE, ADDR, COUNT, DATA, CHECK, HOLD, RUN and ERROR.
REQ-017 In IDLE, RUN or ERROR, load_start SHALL cause a transition to ADDR; load_start SHALL be ignored in every other state.
REQ-018 data_ready SHALL be 1 exactly in ADDR, COUNT, DATA and CHECK.
REQ-019 On an ADDR transfer, the FSM SHALL go to ERROR if data_in[15:ADDR_WIDTH] is nonzero; otherwise it SHALL latch the address and go to COUNT.
REQ-020 On a COUNT transfer, the FSM SHALL go to ERROR if start+count > 2^ADDR_WIDTH (17-bit compare); else to CHECK if count=0; else to DATA.
REQ-021 Each DATA transfer SHALL register mem_write=1, mem_address=current address and mem_data=data_in for exactly the following cycle (latency 1), then increment the address and decrement the remaining count.
REQ-022 The transfer of the last DATA word SHALL move the FSM to CHECK.
REQ-023 The running checksum SHALL be the 16-bit sum, modulo 2^16, of all DATA words, cleared on entry to ADDR.
REQ-024 On a CHECK transfer, a match SHALL move the FSM to HOLD and a mismatch SHALL move it to ERROR.
REQ-025 HOLD SHALL last exactly RESET_HOLD cycles, then the FSM SHALL enter RUN.
REQ-026 done SHALL pulse high for one cycle on entry to RUN.
REQ-027 cpu_reset SHALL be 0 only in RUN; it SHALL be 1 in every other state, including the cycle after load_start is accepted in RUN.
REQ-028 busy SHALL be 1 in ADDR, COUNT, DATA, CHECK and HOLD.
REQ-029 error SHALL be 1 in ERROR, sticky until reset or load_start.
REQ-030 mem_write SHALL be 0 outside the cycle after a DATA transfer; no writes SHALL occur in ERROR, and the memory is left partially written.
REQ-031 Data_valid gaps in any state SHALL stall without side effects.

Reset
REQ-032 When reset=1 at a clock edge, the FSM SHALL go to IDLE and registered outputs SHALL take the values cpu_reset=1, mem_write=0, mem_address=0, mem_data=0, busy=0, done=0 and error=0.
REQ-033 Reset SHALL take priority over load_start and any transfer, and a reset during a load SHALL abort it with no further writes.

Verification (ADDR_WIDTH=10, RESET_HOLD=4)
REQ-034 Reset, then idle -> cpu_reset=1, data_ready=0, mem_write=0, busy=0, error=0.
REQ-035 load_start, then stream 0x0000, 0x0003, 0x1111, 0x2222, 0x3333, 0x6666 -> writes (0x000,0x1111), (0x001,0x2222), (0x002,0x3333); cpu_reset falls 4 cycles after the CHECK transfer; done pulses once.
REQ-036 Same stream with checksum 0x6667 -> error=1, cpu_reset stays 1, data_ready=0, no further writes; a subsequent load_start clears error.
REQ-037 START 0x03FE with COUNT 3 -> ERROR, no writes; START 0x03FE with COUNT 2 and correct checksum -> writes at 0x3FE and 0x3FF, then RUN; START 0x0400 -> ERROR.
REQ-038 COUNT 0 with checksum 0x0000 -> no writes, RUN reached; random data_valid gaps during REQ-035 -> identical writes.
REQ-039 Reset asserted after the 2nd DATA word -> IDLE next cycle, no 3rd write; load_start while in RUN -> cpu_reset=1 next cycle, busy=1.

Source files
------------

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//   Receives a program image over a valid/ready word stream and writes it into
//   instruction memory, holding the processor in reset until the image has
//   been verified.
//
//   Stream format: START address, COUNT, COUNT instruction words, CHECKSUM.
//   The checksum is the 16-bit wrap-around sum of the instruction words.
//   A match holds cpu_reset for RESET_HOLD more cycles and then releases the
//   processor. A mismatch, or an image that does not fit in memory, parks
//   the loader in an error state.
//
// Ports
//   clk, reset    : clock, synchronous active-high reset
//   load_start    : one-cycle request to begin a load (IDLE/RUN/ERROR only)
//   data_valid    : source presents a word on data_in
//   data_in[15:0] : stream word
//   data_ready    : loader accepts a word this cycle
//   mem_write     : instruction-memory write strobe (registered)
//   mem_address   : instruction-memory write address (registered)
//   mem_data      : instruction-memory write data (registered)
//   cpu_reset     : processor reset, low only while running
//   busy          : a load session is in progress
//   done          : one-cycle pulse on entry to RUN
//   error         : load failed, held until reset or a new load_start
// ---------------------------------------------------------------------------
module program_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int RESET_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  data_valid,
    input  logic [15:0]           data_in,
    output logic                  data_ready,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [15:0]           mem_data,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_COUNT, S_DATA, S_CHECK, S_HOLD, S_RUN, S_ERROR
    } state_t;

    localparam int          HW    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [16:0] LIMIT = 17'd1 << ADDR_WIDTH;

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           remaining;
    logic [15:0]           csum;
    logic [HW-1:0]         hold_cnt;

    logic        xfer;
    logic [16:0] start_hi;
    logic        addr_bad;
    logic [16:0] end_addr;

    assign xfer     = data_valid & data_ready;
    // Any address bit above the memory width makes the start address invalid.
    assign start_hi = {1'b0, data_in} >> ADDR_WIDTH;
    assign addr_bad = |start_hi;
    // One past the last word written; 17 bits so a full-memory image compares
    // equal to LIMIT instead of wrapping.
    assign end_addr = 17'(addr) + {1'b0, data_in};

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_RUN, S_ERROR:
                if (load_start) next_state = S_ADDR;
            S_ADDR:
                if (xfer) next_state = addr_bad ? S_ERROR : S_COUNT;
            S_COUNT:
                if (xfer) begin
                    if (end_addr > LIMIT)    next_state = S_ERROR;
                    else if (data_in == '0)  next_state = S_CHECK;
                    else                     next_state = S_DATA;
                end
            S_DATA:
                if (xfer && remaining == 16'd1) next_state = S_CHECK;
            S_CHECK:
                if (xfer) next_state = (data_in == csum) ? S_HOLD : S_ERROR;
            S_HOLD:
                if (hold_cnt == HW'(RESET_HOLD - 1)) next_state = S_RUN;
            default:
                next_state = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        data_ready = 1'b0;
        busy       = 1'b0;
        cpu_reset  = 1'b1;
        error      = 1'b0;
        case (state)
            S_ADDR, S_COUNT, S_DATA, S_CHECK: begin
                data_ready = 1'b1;
                busy       = 1'b1;
            end
            S_HOLD:  busy      = 1'b1;
            S_RUN:   cpu_reset = 1'b0;
            S_ERROR: error     = 1'b1;
            default: ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            addr        <= '0;
            remaining   <= '0;
            csum        <= '0;
            hold_cnt    <= '0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            done        <= 1'b0;
        end else begin
            mem_write <= 1'b0;
            done      <= (state == S_HOLD) && (next_state == S_RUN);
            case (state)
                S_IDLE, S_RUN, S_ERROR:
                    if (load_start) csum <= '0;
                S_ADDR:
                    if (xfer) addr <= data_in[ADDR_WIDTH-1:0];
                S_COUNT:
                    if (xfer) remaining <= data_in;
                S_DATA:
                    if (xfer) begin
                        mem_write   <= 1'b1;
                        mem_address <= addr;
                        mem_data    <= data_in;
                        addr        <= addr + 1'b1;
                        remaining   <= remaining - 16'd1;
                        csum        <= csum + data_in;
                    end
                S_CHECK:
                    if (xfer) hold_cnt <= '0;
                S_HOLD:
                    hold_cnt <= hold_cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
//   Table-driven and randomized checks of program_loader (ADDR_WIDTH=10,
//   RESET_HOLD=4). Each load is described by start/count/checksum; a
//   reference model derives the expected writes and outcome directly from
//   the stream rules, and a monitor collects the writes the DUT performs.
// ---------------------------------------------------------------------------
module tb_program_loader;

    localparam int AW   = 10;
    localparam int HOLD = 4;
    localparam int MEMW = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_start = 1'b0;
    logic          data_valid = 1'b0;
    logic [15:0]   data_in = '0;
    logic          data_ready;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [15:0]   mem_data;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          error;

    program_loader #(.ADDR_WIDTH(AW), .RESET_HOLD(HOLD)) dut (
        .clk(clk), .reset(reset), .load_start(load_start),
        .data_valid(data_valid), .data_in(data_in), .data_ready(data_ready),
        .mem_write(mem_write), .mem_address(mem_address), .mem_data(mem_data),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Write monitor
    int obs_a[$];
    int obs_d[$];
    int done_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (mem_write) begin
            obs_a.push_back(int'(mem_address));
            obs_d.push_back(int'(mem_data));
        end
        if (done) done_cnt++;
    end

    // Stimulus and model state
    logic [15:0] stream[$];
    int          exp_a[$];
    int          exp_d[$];
    bit          exp_err;

    // Reference model: an image is rejected outright if it does not fit in
    // memory; otherwise every word is written and only the checksum decides.
    task automatic build(input int start, input int count, input bit fixed,
                         input bit bad_csum);
        int sum;
        logic [15:0] w;
        stream.delete(); exp_a.delete(); exp_d.delete();
        stream.push_back(16'(start));
        stream.push_back(16'(count));
        sum = 0;
        for (int i = 0; i < count; i++) begin
            w = fixed ? 16'((i + 1) * 16'h1111) : 16'($urandom);
            stream.push_back(w);
            sum = (sum + int'(w)) % 65536;
        end
        if (bad_csum) stream.push_back(16'(sum + 1));
        else          stream.push_back(16'(sum));
        if (start >= MEMW || start + count > MEMW) begin
            exp_err = 1'b1;
        end else begin
            for (int i = 0; i < count; i++) begin
                exp_a.push_back((start + i) % MEMW);
                exp_d.push_back(int'(stream[2 + i]));
            end
            exp_err = bad_csum;
        end
    endtask

    // Start a session and push the stream with random valid gaps; stops early
    // if the loader reports an error. lat counts cycles from the CHECK transfer
    // until cpu_reset drops.
    task automatic do_load(input int gap, output int lat);
        int idx;
        int budget;
        bit drp;
        idx = 0; budget = 3000; drp = 1'b0;
        @(negedge clk); load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
        check("start_error_clear", int'(error), 0);
        check("start_busy", int'(busy), 1);
        check("start_cpu_reset", int'(cpu_reset), 1);
        while (budget > 0) begin
            if (idx >= stream.size() || error) break;
            data_valid = ($urandom_range(99) >= gap);
            data_in    = data_valid ? stream[idx] : 16'($urandom);
            drp        = data_ready;
            @(negedge clk);
            budget--;
            if (data_valid && drp) idx++;
        end
        data_valid = 1'b0;
        if (budget == 0) check("stream_timeout", idx, stream.size());
        lat = 0;
        while (cpu_reset && !error && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_nwrites"}, obs_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
            check({tag, "_waddr"}, obs_a[i], exp_a[i]);
            check({tag, "_wdata"}, obs_d[i], exp_d[i]);
        end
    endtask

    task automatic check_outcome(input string tag, input int lat, input int dn0);
        check({tag, "_error"}, int'(error), int'(exp_err));
        if (exp_err) begin
            check({tag, "_err_cpu_reset"}, int'(cpu_reset), 1);
            check({tag, "_err_ready"}, int'(data_ready), 0);
            check({tag, "_err_busy"}, int'(busy), 0);
        end else begin
            check({tag, "_run_cpu_reset"}, int'(cpu_reset), 0);
            check({tag, "_hold_latency"}, lat, HOLD);
            check({tag, "_done_pulses"}, done_cnt - dn0, 1);
            check({tag, "_run_busy"}, int'(busy), 0);
        end
    endtask

    typedef struct {
        int start;
        int count;
        bit fixed;
        bit bad_csum;
        int gap;
        bit exp_err;
        int exp_writes;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int lat;
        int dn0;
        int st;
        int cn;

        vecs[0]  = '{16'h0000,  3, 1'b1, 1'b0,  0, 1'b0,  3};
        vecs[1]  = '{16'h0000,  3, 1'b1, 1'b1,  0, 1'b1,  3};
        vecs[2]  = '{16'h03FE,  3, 1'b0, 1'b0,  0, 1'b1,  0};
        vecs[3]  = '{16'h03FE,  2, 1'b0, 1'b0,  0, 1'b0,  2};
        vecs[4]  = '{16'h0400,  1, 1'b0, 1'b0,  0, 1'b1,  0};
        vecs[5]  = '{16'h0000,  0, 1'b0, 1'b0,  0, 1'b0,  0};
        vecs[6]  = '{16'h0000,  3, 1'b1, 1'b0, 40, 1'b0,  3};
        vecs[7]  = '{16'h03F0, 16, 1'b0, 1'b0, 20, 1'b0, 16};
        vecs[8]  = '{16'h03F0, 17, 1'b0, 1'b0,  0, 1'b1,  0};
        vecs[9]  = '{16'h8000,  1, 1'b0, 1'b0,  0, 1'b1,  0};
        vecs[10] = '{16'h0155,  5, 1'b0, 1'b1, 30, 1'b1,  5};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cpu_reset", int'(cpu_reset), 1);
        check("rst_ready", int'(data_ready), 0);
        check("rst_mem_write", int'(mem_write), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_error", int'(error), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b0;
        // Stray valid words while idle must be ignored
        data_valid = 1'b1; data_in = 16'h1234;
        repeat (3) @(negedge clk);
        data_valid = 1'b0;
        check("idle_cpu_reset", int'(cpu_reset), 1);
        check("idle_ready", int'(data_ready), 0);
        check("idle_nwrites", obs_a.size(), 0);

        // Table-driven loads
        foreach (vecs[i]) begin
            build(vecs[i].start, vecs[i].count, vecs[i].fixed, vecs[i].bad_csum);
            obs_a.delete(); obs_d.delete();
            dn0 = done_cnt;
            do_load(vecs[i].gap, lat);
            check($sformatf("vec%0d_tbl_error", i), int'(error), int'(vecs[i].exp_err));
            check($sformatf("vec%0d_tbl_nwrites", i), obs_a.size(), vecs[i].exp_writes);
            compare_writes($sformatf("vec%0d", i));
            check_outcome($sformatf("vec%0d", i), lat, dn0);
        end

        // Randomized loads against the model
        for (int r = 0; r < 12; r++) begin
            st = ($urandom_range(9) == 0) ? int'($urandom_range(16'hFFFF))
                                          : int'($urandom_range(MEMW - 1));
            cn = int'($urandom_range(10));
            if ($urandom_range(5) == 0) cn = MEMW - st + 1;
            if (cn > 40) cn = 40;
            build(st, cn, 1'b0, ($urandom_range(3) == 0));
            obs_a.delete(); obs_d.delete();
            dn0 = done_cnt;
            do_load(int'($urandom_range(50)), lat);
            compare_writes($sformatf("rnd%0d", r));
            check_outcome($sformatf("rnd%0d", r), lat, dn0);
        end

        // load_start while running re-asserts cpu_reset on the next cycle
        build(16'h0010, 2, 1'b0, 1'b0);
        do_load(0, lat);
        check("run_before_restart", int'(cpu_reset), 0);
        @(negedge clk); load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
        check("restart_cpu_reset", int'(cpu_reset), 1);
        check("restart_busy", int'(busy), 1);
        check("restart_ready", int'(data_ready), 1);

        // Reset after the 2nd DATA word aborts the load with no 3rd write
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        obs_a.delete(); obs_d.delete();
        load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
        data_valid = 1'b1; data_in = 16'h0000;
        @(negedge clk); data_in = 16'h0003;
        @(negedge clk); data_in = 16'hAAAA;
        @(negedge clk); data_in = 16'hBBBB;
        @(negedge clk); reset = 1'b1; data_in = 16'hCCCC;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_ready", int'(data_ready), 0);
        check("abort_cpu_reset", int'(cpu_reset), 1);
        check("abort_mem_write", int'(mem_write), 0);
        check("abort_mem_address", int'(mem_address), 0);
        reset = 1'b0; data_valid = 1'b1;
        repeat (4) @(negedge clk);
        data_valid = 1'b0;
        check("abort_nwrites", obs_a.size(), 2);
        if (obs_a.size() >= 2) begin
            check("abort_w1_addr", obs_a[1], 1);
            check("abort_w1_data", obs_d[1], 16'hBBBB);
        end
        check("abort_idle_busy", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
